// File: rtl/ddr_app_pkg.sv
// Shared constants, state encoding and LFSR helper for the MIG app_* responder.
// Optional stall LFSR is enabled by defining DDR_APP_STALL_EN.
package ddr_app_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic {
    CALIB,
    RUN
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Galois form, right shift, maximal-length 16-bit polynomial
  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0);
  endfunction

endpackage

// File: rtl/ddr_app_fifo.sv
// Small synchronous FIFO with registered occupancy; full/empty
// derive from the count register only, never from same-cycle pops.
module ddr_app_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  buf_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = buf_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) buf_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ddr_app_responder.sv
// Cycle-accurate MIG app_* responder: calibration delay, cmd/wdf queues,
// byte-masked store, fixed-latency reads. DDR_APP_STALL_EN adds LFSR backpressure.
module ddr_app_responder
  import ddr_app_pkg::*;
#(
  parameter int ADDR_W       = 27,
  parameter int DATA_W       = 128,
  parameter int MEM_AW       = 10,
  parameter int RD_LAT       = 8,
  parameter int CQ_DEPTH     = 4,
  parameter int WQ_DEPTH     = 4,
  parameter int CALIB_CYCLES = 64
) (
  input  logic                ui_clk_i,
  input  logic                ui_rst_n,
  input  logic [ADDR_W-1:0]   app_addr,
  input  logic [2:0]          app_cmd,
  input  logic                app_en,
  output logic                app_rdy,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_wren,
  input  logic                app_wdf_end,
  output logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end,
  output logic                init_calib_complete,
  output logic                cmd_err_o
);

  localparam int MW  = DATA_W / 8;
  localparam int CW  = $clog2(CALIB_CYCLES + 1);
  localparam int CQW = MEM_AW + 1;
  localparam int WQW = DATA_W + MW;

  state_e          state_q, state_d;
  logic [CW-1:0]   cal_q, cal_d;
  logic            err_q, err_d;
  logic            run;
  logic            stall_c;
  logic            stall_w;

  logic            fire;
  logic            legal;
  logic            wfire;
  logic [CQW-1:0]  cq_din, cq_dout;
  logic            cq_full, cq_empty;
  logic [WQW-1:0]  wq_din, wq_dout;
  logic            wq_full, wq_empty;
  logic [MEM_AW-1:0] hd_idx;
  logic            hd_rd;
  logic [DATA_W-1:0] wq_data;
  logic [MW-1:0]   wq_mask;
  logic            exec_wr;
  logic            exec_rd;

  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  logic unused_addr;
  assign unused_addr = ^{app_addr[ADDR_W-1:MEM_AW+3],
                         app_addr[2:0]};

  assign run = state_q == RUN;

`ifdef DDR_APP_STALL_EN
  logic [15:0] lfsr_q;
  logic        unused_lfsr;

  always_ff @(posedge ui_clk_i or negedge ui_rst_n) begin
    if (!ui_rst_n) lfsr_q <= LFSR_SEED;
    else if (run)  lfsr_q <= lfsr_next(lfsr_q);
  end

  assign stall_c     = lfsr_q[1:0] == 2'b00;
  assign stall_w     = lfsr_q[3:2] == 2'b00;
  assign unused_lfsr = ^lfsr_q[15:4];
`else
  assign stall_c = 1'b0;
  assign stall_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cal_d   = cal_q;
    unique case (state_q)
      CALIB: begin
        if (cal_q == CW'(CALIB_CYCLES - 1)) state_d = RUN;
        else cal_d = cal_q + 1'b1;
      end
      RUN: ;
      default: state_d = CALIB;
    endcase
  end

  assign app_rdy     = run & ~cq_full & ~stall_c;
  assign app_wdf_rdy = run & ~wq_full & ~stall_w;

  assign fire  = app_en & app_rdy;
  assign legal = (app_cmd == CMD_WRITE) | (app_cmd == CMD_READ);
  assign wfire = app_wdf_wren & app_wdf_rdy;

  assign err_d = err_q | (fire & ~legal)
               | (app_wdf_wren & ~app_wdf_end);

  always_ff @(posedge ui_clk_i or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      state_q <= CALIB;
      cal_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cal_q   <= cal_d;
      err_q   <= err_d;
    end
  end

  assign cq_din = {app_addr[MEM_AW+2:3], app_cmd == CMD_READ};
  assign wq_din = {app_wdf_data, app_wdf_mask};

  ddr_app_fifo #(.W(CQW), .DEPTH(CQ_DEPTH)) u_cq (
    .clk_i   (ui_clk_i),
    .rst_ni  (ui_rst_n),
    .push_i  (fire & legal),
    .din_i   (cq_din),
    .pop_i   (exec_wr | exec_rd),
    .dout_o  (cq_dout),
    .full_o  (cq_full),
    .empty_o (cq_empty)
  );

  ddr_app_fifo #(.W(WQW), .DEPTH(WQ_DEPTH)) u_wq (
    .clk_i   (ui_clk_i),
    .rst_ni  (ui_rst_n),
    .push_i  (wfire),
    .din_i   (wq_din),
    .pop_i   (exec_wr),
    .dout_o  (wq_dout),
    .full_o  (wq_full),
    .empty_o (wq_empty)
  );

  assign {hd_idx, hd_rd}    = cq_dout;
  assign {wq_data, wq_mask} = wq_dout;

  // A write head without its data blocks everything behind it
  assign exec_wr = ~cq_empty & ~hd_rd & ~wq_empty;
  assign exec_rd = ~cq_empty & hd_rd;

  always_ff @(posedge ui_clk_i) begin
    if (exec_wr) begin
      for (int b = 0; b < MW; b++) begin
        if (!wq_mask[b])
          mem[hd_idx][b*8 +: 8] <= wq_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge ui_clk_i or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q    <= {vld_q[RD_LAT-2:0], exec_rd};
      dat_q[0] <= exec_rd ? mem[hd_idx] : '0;
      for (int i = 1; i < RD_LAT; i++) dat_q[i] <= dat_q[i-1];
    end
  end

  assign app_rd_data         = dat_q[RD_LAT-1];
  assign app_rd_data_valid   = vld_q[RD_LAT-1];
  assign app_rd_data_end     = vld_q[RD_LAT-1];
  assign init_calib_complete = run;
  assign cmd_err_o           = err_q;

endmodule

// File: tb/tb_ddr_app_responder.sv
// Directed bench for ddr_app_responder: calibration, RAW, masking,
// backpressure, aliasing, illegal command and mid-operation reset.
module tb_ddr_app_responder;

  logic         clk = 1'b0;
  logic         ui_rst_n;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;
  logic         cmd_err_o;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ddr_app_responder dut (
    .ui_clk_i            (clk),
    .ui_rst_n            (ui_rst_n),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete),
    .cmd_err_o           (cmd_err_o)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [26:0] a,
                    input logic [127:0] d,
                    input logic [15:0] m,
                    input bit data_first);
    app_wdf_data = d;
    app_wdf_mask = m;
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    if (!data_first) begin
      app_en = 1'b1; app_cmd = 3'b000; app_addr = a;
    end
    @(negedge clk);
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    if (data_first) begin
      app_en = 1'b1; app_cmd = 3'b000; app_addr = a;
      @(negedge clk);
    end
    app_en = 1'b0;
  endtask

  // Read on an idle queue: valid must land 9 negedges after the drive
  // (accept cycle, execute cycle, then RD_LAT pipe stages).
  task automatic rd(input logic [26:0] a,
                    input logic [127:0] exp,
                    input string tag);
    int k;
    app_en = 1'b1; app_cmd = 3'b001; app_addr = a;
    k = 0;
    while (!app_rdy && k < 50) begin
      @(negedge clk); k++;
    end
    @(negedge clk);
    app_en = 1'b0;
    k = 1;
    while (!app_rd_data_valid && k < 40) begin
      @(negedge clk); k++;
    end
    chk({tag, "_vld"}, 128'(app_rd_data_valid), 128'd1);
    chk({tag, "_end"}, 128'(app_rd_data_end), 128'd1);
    chk({tag, "_dat"}, app_rd_data, exp);
    chk({tag, "_lat"}, 128'(k), 128'd9);
    @(negedge clk);
  endtask

  function automatic logic [127:0] bp_dat(input int i);
    return {4{32'hA000_0000 + 32'(i)}};
  endfunction

  initial begin
    logic [127:0] got [6];
    int ci, di, ri, vi, first, last, nv;
    bit rdy_c, rdy_w;

    ui_rst_n     = 1'b0;
    app_addr     = '0;
    app_cmd      = 3'b000;
    app_en       = 1'b0;
    app_wdf_data = '0;
    app_wdf_mask = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_rdy",   128'(app_rdy), 128'd0);
    chk("rst_wrdy",  128'(app_wdf_rdy), 128'd0);
    chk("rst_vld",   128'(app_rd_data_valid), 128'd0);
    chk("rst_dat",   app_rd_data, 128'd0);
    chk("rst_calib", 128'(init_calib_complete), 128'd0);
    chk("rst_err",   128'(cmd_err_o), 128'd0);

    // Calibration: 64 rising edges after release
    ui_rst_n = 1'b1;
    repeat (63) @(negedge clk);
    chk("cal63_done", 128'(init_calib_complete), 128'd0);
    chk("cal63_rdy",  128'(app_rdy), 128'd0);
    chk("cal63_wrdy", 128'(app_wdf_rdy), 128'd0);
    @(negedge clk);
    chk("cal64_done", 128'(init_calib_complete), 128'd1);
    chk("cal64_rdy",  128'(app_rdy), 128'd1);
    chk("cal64_wrdy", 128'(app_wdf_rdy), 128'd1);

    // Write with data one cycle ahead, then read back
    wr(27'h000_0040, 128'h0123456789ABCDEF0123456789ABCDEF,
       16'h0000, 1'b1);
    rd(27'h000_0040, 128'h0123456789ABCDEF0123456789ABCDEF,
       "raw");

    // Byte mask: lower 8 bytes masked keep FF
    wr(27'h000_0100, {128{1'b1}}, 16'h0000, 1'b0);
    wr(27'h000_0100, 128'h0, 16'h00FF, 1'b0);
    rd(27'h000_0100,
       128'h0000000000000000_FFFFFFFFFFFFFFFF, "mask");

    // Backpressure: 6 write commands, no data yet
    ci = 0;
    di = 0;
    for (int c = 0; c < 10; c++) begin
      app_en   = ci < 6;
      app_cmd  = 3'b000;
      app_addr = 27'((16 + ci) << 3);
      rdy_c    = app_rdy;
      @(negedge clk);
      if (app_en && rdy_c) ci++;
    end
    app_en = 1'b0;
    chk("bp_acc4", 128'(ci), 128'd4);
    chk("bp_rdy0", 128'(app_rdy), 128'd0);

    for (int c = 0; c < 40 && (ci < 6 || di < 6); c++) begin
      app_en       = ci < 6;
      app_cmd      = 3'b000;
      app_addr     = 27'((16 + ci) << 3);
      app_wdf_wren = di < 6;
      app_wdf_end  = di < 6;
      app_wdf_data = bp_dat(di);
      app_wdf_mask = '0;
      rdy_c = app_rdy;
      rdy_w = app_wdf_rdy;
      @(negedge clk);
      if (app_en && rdy_c) ci++;
      if (app_wdf_wren && rdy_w) di++;
    end
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    chk("bp_cmd6", 128'(ci), 128'd6);
    chk("bp_dat6", 128'(di), 128'd6);
    repeat (4) @(negedge clk);

    // Six back-to-back reads
    ri = 0; vi = 0; first = -1; last = -1;
    for (int c = 0; c < 30; c++) begin
      if (app_rd_data_valid) begin
        if (vi < 6) got[vi] = app_rd_data;
        if (first < 0) first = c;
        last = c;
        vi++;
      end
      app_en   = ri < 6;
      app_cmd  = 3'b001;
      app_addr = 27'((16 + ri) << 3);
      rdy_c    = app_rdy;
      @(negedge clk);
      if (app_en && rdy_c) ri++;
    end
    app_en = 1'b0;
    chk("b2b_cnt",  128'(vi), 128'd6);
    chk("b2b_span", 128'(last - first), 128'd5);
    for (int i = 0; i < 6; i++)
      chk($sformatf("b2b_dat%0d", i), got[i], bp_dat(i));

    // Alias: idx 1024 wraps to idx 0
    wr(27'h000_0000, 128'hFEED_FACE_CAFE_BEEF_1234_5678_9ABC_DEF0,
       16'h0000, 1'b0);
    rd(27'h000_2000, 128'hFEED_FACE_CAFE_BEEF_1234_5678_9ABC_DEF0,
       "alias");
    chk("err_clean", 128'(cmd_err_o), 128'd0);

    // Illegal command
    app_en = 1'b1; app_cmd = 3'b010; app_addr = 27'h0;
    @(negedge clk);
    app_en = 1'b0;
    nv = 0;
    for (int c = 0; c < 15; c++) begin
      if (app_rd_data_valid) nv++;
      @(negedge clk);
    end
    chk("ill_err", 128'(cmd_err_o), 128'd1);
    chk("ill_novld", 128'(nv), 128'd0);

    // Reset with three reads in flight
    for (int c = 0; c < 3; c++) begin
      app_en = 1'b1; app_cmd = 3'b001; app_addr = 27'h0;
      @(negedge clk);
    end
    app_en = 1'b0;
    @(negedge clk);
    ui_rst_n = 1'b0;
    nv = 0;
    for (int c = 0; c < 3; c++) begin
      if (app_rd_data_valid) nv++;
      @(negedge clk);
    end
    chk("mrst_err",   128'(cmd_err_o), 128'd0);
    chk("mrst_calib", 128'(init_calib_complete), 128'd0);
    ui_rst_n = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (app_rd_data_valid) nv++;
      @(negedge clk);
    end
    chk("mrst_novld", 128'(nv), 128'd0);
    chk("mrst_recal", 128'(init_calib_complete), 128'd1);
    rd(27'h000_0000, 128'hFEED_FACE_CAFE_BEEF_1234_5678_9ABC_DEF0,
       "mrst_rd");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_app_responder.md
Name: ddr_app_responder

Overview:
- Synthesizable, cycle-accurate responder for the MIG user (app_*) interface. It plays the memory-controller side that ddr_ctrl drives.
- Replaces the DDR2 PHY/MIG plus external memory model in DNN simulations, so traffic runs in thousands of cycles rather than millions.
- Provides calibration delay, command/write-data handshakes, byte-masked storage and fixed-latency in-order read return.

Parameters:
- ADDR_W, 27, app_addr width.
- DATA_W, 128, app data width; 4:1 UI over the x16 DDR2 bus, one beat per BL8.
- MEM_AW, 10, log2 of stored 128-bit words. Higher address bits alias.
- RD_LAT, 8, cycles from read-command execution to app_rd_data_valid (>=2).
- CQ_DEPTH, 4, command FIFO depth (power of 2).
- WQ_DEPTH, 4, write-data FIFO depth (power of 2).
- CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises.

Ports:
- ui_clk_i  in  1  UI clock; all logic is on its rising edge.
- ui_rst_n  in  1  asynchronous active-low reset.
- app_addr  in  ADDR_W  command address, in 16-bit column units; word index = app_addr[MEM_AW+2:3].
- app_cmd  in  3  3'b000 write, 3'b001 read, others illegal.
- app_en  in  1  command valid.
- app_rdy  out  1  command accept.
- app_wdf_data  in  DATA_W  write data.
- app_wdf_mask  in  DATA_W/8  byte mask; 1 = byte not written.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat; must equal app_wdf_wren.
- app_wdf_rdy  out  1  write data accept.
- app_rd_data  out  DATA_W  read data.
- app_rd_data_valid  out  1  read data strobe.
- app_rd_data_end  out  1  equals app_rd_data_valid (single-beat).
- init_calib_complete  out  1  calibration done.
- cmd_err_o  out  1  sticky: illegal cmd, or wdf_wren without wdf_end.

Behaviour:
- Reset values: app_rdy=0, app_wdf_rdy=0, app_rd_data_valid=0, app_rd_data_end=0, app_rd_data=0, init_calib_complete=0, cmd_err_o=0. FIFOs, read pipe and calib counter are cleared. The memory array is not reset.
- FSM CALIB -> RUN:
  - CALIB counts CALIB_CYCLES cycles after reset deassertion.
  - init_calib_complete rises on the cycle of the CALIB -> RUN transition and stays high until reset.
  - In CALIB, app_rdy=0 and app_wdf_rdy=0.
- Command accept: fire = app_en & app_rdy. In RUN, app_rdy = !cq_full. It does not depend on app_cmd or app_en.
  - An illegal cmd is accepted, sets cmd_err_o and is discarded (not enqueued).
- Write-data accept: app_wdf_wren & app_wdf_rdy. In RUN, app_wdf_rdy = !wq_full.
  - Data may precede, coincide with, or follow its write command, matching MIG semantics. Data is paired with write commands strictly in order.
- Execution, at most one command per cycle from the cq head, in order:
  - WRITE head: executes only when wq is non-empty. Pops both and writes unmasked bytes to mem[idx]. A write head with empty wq stalls the queue, so later reads wait.
  - READ head: pops, reads mem[idx] and enters the RD_LAT-stage valid/data pipe. Valid and data appear exactly RD_LAT cycles after execution. Back-to-back reads give back-to-back valids.
- Ordering: a read always returns data that includes all earlier-accepted writes to the same index (read-after-write is guaranteed by in-order execution).
- Simultaneous enqueue and dequeue on the same FIFO in one cycle: both happen. A full FIFO that dequeues this cycle still reports full, so app_rdy/app_wdf_rdy is registered from occupancy.
- Address wrap: the index uses only app_addr[MEM_AW+2:3]; app_addr[2:0] is ignored.
- Reset mid-operation: in-flight reads and queued writes are lost. No valid is emitted after reset assertion.

Optional Feature:
- DDR_APP_STALL_EN defined: a 16-bit LFSR (seed 16'hACE1, advancing every cycle in RUN) forces app_rdy=0 when lfsr[1:0]==2'b00 and app_wdf_rdy=0 when lfsr[3:2]==2'b00. This exercises ddr_ctrl backpressure.
- Not defined: app_rdy and app_wdf_rdy are gated only by calibration state and FIFO full.

Decomposition:
- Package ddr_app_pkg:
  - CMD_WRITE=3'b000, CMD_READ=3'b001.
  - State enum {CALIB, RUN}.
  - LFSR seed and taps.
- Sub-module ddr_app_fifo (parameterized width/depth synchronous FIFO with full/empty), instanced for cq ({addr idx, is_read}) and wq ({data, mask}).

Test Plan:
- Calibration: release reset; init_calib_complete rises at cycle 64; app_rdy and app_wdf_rdy are 0 before it and 1 after.
- Write then read: write 128'h0123...CDEF to addr 27'h000_0040 with data one cycle before cmd, then read addr 40 -> valid+end exactly RD_LAT=8 cycles after read execution, data matches.
- Byte mask: write all-FF, then write 128'h0 with mask 16'h00FF, read back -> 128'h0000...0000_FFFF...FF (upper 8 bytes 00, lower 8 bytes FF).
- Backpressure:
  - Issue 6 writes with wdf_wren held low -> app_rdy drops after 4 accepted commands.
  - Supply data -> all 6 complete.
  - Then 6 back-to-back reads -> 6 consecutive valid cycles, in order.
- Alias and illegal command:
  - Write to idx 0, read addr 27'h000_2000 (idx 1024) -> same data.
  - app_cmd=3'b010 -> cmd_err_o=1, no read valid.
- Reset mid-operation: assert ui_rst_n low with 3 reads in flight -> valid never asserts; after re-calibration, a read of previously written data still matches.
